// File: rtl/mem_stage_pipelined_if.sv
// EX <-> MEM request/response bundle for the pipelined memory stage.
// master = EX side, slave = memory stage.
interface mem_stage_pipelined_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              MemWrite;
  logic              MemRead;
  logic              Branch;
  logic              Zero;
  logic              rsp_valid;
  logic [DATA_W-1:0] read_data_mem;
  logic              PCSrc_out;
  logic              addr_err;
  logic              busy;

  modport master (
    output req_valid, address, write_data,
    output MemWrite, MemRead, Branch, Zero,
    input  req_ready, rsp_valid, read_data_mem,
    input  PCSrc_out, addr_err, busy
  );

  modport slave (
    input  req_valid, address, write_data,
    input  MemWrite, MemRead, Branch, Zero,
    output req_ready, rsp_valid, read_data_mem,
    output PCSrc_out, addr_err, busy
  );
endinterface

// File: rtl/mem_stage_pipelined.sv
// Pipelined MEM stage: word RAM, RD_LAT-cycle loads, single-cycle
// stores/no-ops, registered Branch&Zero aligned with the response.
module mem_stage_pipelined #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_stage_pipelined_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT =
    (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_hold_q;
  logic              pc_q;
  logic              err_q;
  logic              pc_hold_q;
  logic              err_hold_q;

  logic              accept;
  logic              in_range;
  logic              is_rd;
  logic              slow;
  logic              br_d;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  assign bus.req_ready     = (state_q != WAIT);
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.busy          = (state_q == WAIT);
  assign bus.read_data_mem = rdata_q;
  assign bus.PCSrc_out     = pc_q;
  assign bus.addr_err      = err_q;

  // Extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range = {1'b0, bus.address} < (ADDR_W + 1)'(DEPTH);
  assign accept   = bus.req_valid & bus.req_ready;
  assign idx      = bus.address[IDX_W-1:0];
  assign rd_word  = in_range ? mem_q[idx] : '0;
  assign is_rd    = bus.MemRead & ~bus.MemWrite;
  assign slow     = is_rd && (RD_LAT > 1);
  assign br_d     = bus.Branch & bus.Zero;

  always_ff @(posedge clk) begin
    if (accept && bus.MemWrite && in_range) begin
      mem_q[idx] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      pc_q       <= 1'b0;
      err_q      <= 1'b0;
      rd_hold_q  <= '0;
      pc_hold_q  <= 1'b0;
      err_hold_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RESP: begin
          if (accept && slow) begin
            state_q    <= WAIT;
            cnt_q      <= CNT_INIT;
            rd_hold_q  <= rd_word;
            pc_hold_q  <= br_d;
            err_hold_q <= ~in_range;
          end else if (accept) begin
            state_q <= RESP;
            pc_q    <= br_d;
            err_q   <= ~in_range;
            if (is_rd) begin
              rdata_q <= rd_word;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            rdata_q <= rd_hold_q;
            pc_q    <= pc_hold_q;
            err_q   <= err_hold_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Directed bench for mem_stage_pipelined: three instances with
// RD_LAT 1, 3 and 4 exercised in one linear sequence.
module tb_mem_stage_pipelined;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_pipelined_if #(.DATA_W(16), .ADDR_W(16)) b1 ();
  mem_stage_pipelined_if #(.DATA_W(16), .ADDR_W(16)) b3 ();
  mem_stage_pipelined_if #(.DATA_W(16), .ADDR_W(16)) b4 ();

  mem_stage_pipelined #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_stage_pipelined #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(3))
    u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  mem_stage_pipelined #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .RD_LAT(4))
    u4 (.clk(clk), .rst_n(rst4_n), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic w,
                       input logic r, input logic [15:0] a,
                       input logic [15:0] d, input logic b,
                       input logic z);
    case (s)
      1: begin
        b1.req_valid = v; b1.MemWrite = w; b1.MemRead = r;
        b1.address = a; b1.write_data = d; b1.Branch = b; b1.Zero = z;
      end
      3: begin
        b3.req_valid = v; b3.MemWrite = w; b3.MemRead = r;
        b3.address = a; b3.write_data = d; b3.Branch = b; b3.Zero = z;
      end
      default: begin
        b4.req_valid = v; b4.MemWrite = w; b4.MemRead = r;
        b4.address = a; b4.write_data = d; b4.Branch = b; b4.Zero = z;
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(3, 0, 0, 0, 0, 0, 0, 0);
    drive(4, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_rsp", b1.rsp_valid, 0);
    chk("rst_rdata", b1.read_data_mem, 0);
    chk("rst_pc", b1.PCSrc_out, 0);
    chk("rst_err", b1.addr_err, 0);
    chk("rst_busy", b3.busy, 0);
    chk("rst_ready", b3.req_ready, 1);
    #10;
    rst_n = 1'b1;
    rst4_n = 1'b1;

    // RD_LAT=1: write then read back-to-back
    drive(1, 1, 1, 0, 16'd5, 16'hBEEF, 0, 0);
    tick();
    chk("t1_wr_rsp", b1.rsp_valid, 1);
    chk("t1_wr_rdata", b1.read_data_mem, 0);
    drive(1, 1, 0, 1, 16'd5, 16'h0000, 0, 0);
    tick();
    chk("t1_rd_rsp", b1.rsp_valid, 1);
    chk("t1_rd_data", b1.read_data_mem, 16'hBEEF);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_idle_rsp", b1.rsp_valid, 0);
    chk("t1_idle_hold", b1.read_data_mem, 16'hBEEF);

    // Branch resolution
    drive(1, 1, 0, 0, 16'd0, 16'h0000, 1, 1);
    tick();
    chk("t3_br_rsp", b1.rsp_valid, 1);
    chk("t3_br_pc1", b1.PCSrc_out, 1);
    chk("t3_br_rdata", b1.read_data_mem, 16'hBEEF);
    drive(1, 1, 0, 0, 16'd0, 16'h0000, 1, 0);
    tick();
    chk("t3_br_pc0", b1.PCSrc_out, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_pc_hold", b1.PCSrc_out, 0);

    // Out-of-range accesses and aliasing
    drive(1, 1, 1, 0, 16'd44, 16'h5A5A, 0, 0);
    tick();
    chk("t4_wr44_err", b1.addr_err, 0);
    drive(1, 1, 1, 0, 16'd300, 16'h1234, 0, 0);
    tick();
    chk("t4_wr300_rsp", b1.rsp_valid, 1);
    chk("t4_wr300_err", b1.addr_err, 1);
    drive(1, 1, 0, 1, 16'd44, 16'h0000, 0, 0);
    tick();
    chk("t4_rd44_data", b1.read_data_mem, 16'h5A5A);
    chk("t4_rd44_err", b1.addr_err, 0);
    drive(1, 1, 0, 1, 16'd300, 16'h0000, 0, 0);
    tick();
    chk("t4_rd300_data", b1.read_data_mem, 0);
    chk("t4_rd300_err", b1.addr_err, 1);

    // MemRead and MemWrite together: write wins
    drive(1, 1, 1, 1, 16'd7, 16'h00AA, 0, 0);
    tick();
    chk("t5_rw_rsp", b1.rsp_valid, 1);
    chk("t5_rw_rdata", b1.read_data_mem, 0);
    chk("t5_rw_err", b1.addr_err, 0);
    drive(1, 1, 0, 1, 16'd7, 16'h0000, 0, 0);
    tick();
    chk("t5_rd7_data", b1.read_data_mem, 16'h00AA);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_idle_rsp", b1.rsp_valid, 0);

    // RD_LAT=3: wait states and refused request in WAIT
    drive(3, 1, 1, 0, 16'd5, 16'hBEEF, 0, 0);
    tick();
    chk("t2_wr_rsp", b3.rsp_valid, 1);
    chk("t2_wr_busy", b3.busy, 0);
    drive(3, 1, 0, 1, 16'd5, 16'h0000, 0, 0);
    tick();
    chk("t2_w1_busy", b3.busy, 1);
    chk("t2_w1_ready", b3.req_ready, 0);
    chk("t2_w1_rsp", b3.rsp_valid, 0);
    drive(3, 1, 1, 0, 16'd5, 16'h1111, 0, 0);
    tick();
    chk("t2_w2_busy", b3.busy, 1);
    chk("t2_w2_ready", b3.req_ready, 0);
    chk("t2_w2_rsp", b3.rsp_valid, 0);
    tick();
    chk("t2_r_rsp", b3.rsp_valid, 1);
    chk("t2_r_data", b3.read_data_mem, 16'hBEEF);
    chk("t2_r_busy", b3.busy, 0);
    chk("t2_r_ready", b3.req_ready, 1);
    drive(3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_idle_rsp", b3.rsp_valid, 0);
    drive(3, 1, 0, 1, 16'd5, 16'h0000, 0, 0);
    tick();
    drive(3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t2_re_rsp", b3.rsp_valid, 1);
    chk("t2_re_data", b3.read_data_mem, 16'hBEEF);

    // RD_LAT=4: full load, then reset during WAIT
    drive(4, 1, 1, 0, 16'd9, 16'h7777, 0, 0);
    tick();
    chk("t6_wr_rsp", b4.rsp_valid, 1);
    drive(4, 1, 0, 1, 16'd9, 16'h0000, 1, 1);
    tick();
    drive(4, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t6_w3_rsp", b4.rsp_valid, 0);
    tick();
    chk("t6_r_rsp", b4.rsp_valid, 1);
    chk("t6_r_data", b4.read_data_mem, 16'h7777);
    chk("t6_r_pc", b4.PCSrc_out, 1);
    drive(4, 1, 0, 1, 16'd9, 16'h0000, 0, 0);
    tick();
    drive(4, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t6_pre_busy", b4.busy, 1);
    #1;
    rst4_n = 1'b0;
    #1;
    chk("t6_rst_busy", b4.busy, 0);
    chk("t6_rst_rsp", b4.rsp_valid, 0);
    chk("t6_rst_data", b4.read_data_mem, 0);
    chk("t6_rst_pc", b4.PCSrc_out, 0);
    chk("t6_rst_err", b4.addr_err, 0);
    #2;
    rst4_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_drop_rsp", b4.rsp_valid, 0);
      chk("t6_drop_ready", b4.req_ready, 1);
    end
    drive(4, 1, 0, 1, 16'd9, 16'h0000, 0, 0);
    tick();
    drive(4, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("t6_post_rsp", b4.rsp_valid, 1);
    chk("t6_post_data", b4.read_data_mem, 16'h7777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
